// File: rtl/aud_in_multi.sv
// Audio ADC capture: generates BCLK/ADCLRCK from MCLK, deserialises left-justified
// ADCDAT and writes mono/stereo samples into an address window via a valid/ack port.
module aud_in_multi #(
  parameter int DATA_W   = 16,
  parameter int SLOT_W   = 32,
  parameter int BCLK_DIV = 24,
  parameter int ADDR_W   = 18
) (
  input  logic              MCLK,
  input  logic              reset,
  input  logic              enable,
  input  logic              stereo,
  input  logic              loop,
  input  logic [ADDR_W-1:0] AUD_ADDR1,
  input  logic [ADDR_W-1:0] AUD_ADDR2,
  output logic              AUD_BCLK,
  output logic              AUD_ADCLRCK,
  input  logic              AUD_ADCDAT,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [DATA_W-1:0] MEM_DATA,
  output logic              MEM_WE,
  input  logic              MEM_ACK,
  output logic              overrun,
  output logic              done
);

  localparam int DIV_W = $clog2(2*BCLK_DIV);
  localparam int BIT_W = $clog2(SLOT_W+1);
  localparam logic [DIV_W-1:0] RISE_CNT = DIV_W'(BCLK_DIV-1);
  localparam logic [DIV_W-1:0] FALL_CNT = DIV_W'(2*BCLK_DIV-1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(SLOT_W-1);
  localparam logic [BIT_W-1:0] LAST_DAT = BIT_W'(DATA_W-1);
  localparam logic [BIT_W-1:0] DATA_LIM = BIT_W'(DATA_W);

  typedef enum logic [2:0] {S_IDLE, S_ARM, S_SYNC, S_RUN, S_DONE} state_t;

  state_t            state;
  logic [DIV_W-1:0]  div;
  logic [BIT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] shreg;
  logic [ADDR_W-1:0] start_q;
  logic [ADDR_W-1:0] end_q;
  logic              stereo_q;
  logic              loop_q;

  logic              rise_tick;
  logic              fall_tick;
  logic              bit_wrap;
  logic              sample_done;
  logic              frame_start;
  logic              want_ch;
  logic [DATA_W-1:0] sample_word;
  logic [ADDR_W-1:0] addr_inc;
  logic              ack_now;
  logic              at_end;
  logic              finishing;

  assign rise_tick   = (div == RISE_CNT);
  assign fall_tick   = (div == FALL_CNT);
  assign bit_wrap    = (bit_cnt == LAST_BIT);
  assign sample_done = rise_tick && (bit_cnt == LAST_DAT);
  // ADCLRCK is about to fall: the next slot is a left slot
  assign frame_start = fall_tick && bit_wrap && AUD_ADCLRCK;
  assign want_ch     = !AUD_ADCLRCK || stereo_q;
  assign sample_word = (shreg << 1) | DATA_W'(AUD_ADCDAT);
  assign addr_inc    = MEM_ADDR + ADDR_W'(1);
  assign ack_now     = MEM_WE && MEM_ACK;
  assign at_end      = (addr_inc == end_q);
  assign finishing   = ack_now && at_end && !loop_q;

  // Serial clocks and shifter run from reset regardless of recording state
  always_ff @(posedge MCLK) begin
    if (reset) begin
      div         <= '0;
      AUD_BCLK    <= 1'b0;
      bit_cnt     <= '0;
      AUD_ADCLRCK <= 1'b1;
      shreg       <= '0;
    end else begin
      if (fall_tick) div <= '0;
      else           div <= div + DIV_W'(1);

      if (rise_tick)      AUD_BCLK <= 1'b1;
      else if (fall_tick) AUD_BCLK <= 1'b0;

      if (fall_tick) begin
        if (bit_wrap) begin
          bit_cnt     <= '0;
          AUD_ADCLRCK <= ~AUD_ADCLRCK;
        end else begin
          bit_cnt <= bit_cnt + BIT_W'(1);
        end
      end

      if (rise_tick && (bit_cnt < DATA_LIM)) shreg <= sample_word;
    end
  end

  always_ff @(posedge MCLK) begin
    if (reset) begin
      state    <= S_IDLE;
      MEM_WE   <= 1'b0;
      MEM_ADDR <= '0;
      MEM_DATA <= '0;
      overrun  <= 1'b0;
      done     <= 1'b0;
      start_q  <= '0;
      end_q    <= '0;
      stereo_q <= 1'b0;
      loop_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done   <= 1'b0;
          MEM_WE <= 1'b0;
          if (enable) state <= S_ARM;
        end

        S_ARM: begin
          start_q  <= AUD_ADDR1;
          end_q    <= AUD_ADDR2;
          stereo_q <= stereo;
          loop_q   <= loop;
          overrun  <= 1'b0;
          MEM_ADDR <= AUD_ADDR1;
          if (AUD_ADDR1 >= AUD_ADDR2) begin
            state <= S_DONE;
            done  <= 1'b1;
          end else begin
            state <= S_SYNC;
          end
        end

        S_SYNC: begin
          if (!enable)          state <= S_IDLE;
          else if (frame_start) state <= S_RUN;
        end

        S_RUN: begin
          if (ack_now) begin
            MEM_WE   <= 1'b0;
            MEM_ADDR <= (at_end && loop_q) ? start_q : addr_inc;
          end
          if (!enable) begin
            // let an outstanding write drain before going idle
            if (!MEM_WE || MEM_ACK) state <= S_IDLE;
          end else if (finishing) begin
            state <= S_DONE;
            done  <= 1'b1;
          end else if (sample_done && want_ch) begin
            if (!MEM_WE || MEM_ACK) begin
              MEM_DATA <= sample_word;
              MEM_WE   <= 1'b1;
            end else begin
              overrun <= 1'b1;
            end
          end
        end

        S_DONE: begin
          MEM_WE <= 1'b0;
          if (!enable) begin
            state <= S_IDLE;
            done  <= 1'b0;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aud_in_multi.sv
// Randomised bench for aud_in_multi with a slot-level reference model of the capture path.
module tb_aud_in_multi;

  localparam int DW = 6;
  localparam int SW = 8;
  localparam int BD = 2;
  localparam int AW = 8;

  logic          MCLK = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic          stereo = 1'b0;
  logic          loop = 1'b0;
  logic [AW-1:0] a1 = '0;
  logic [AW-1:0] a2 = '0;
  logic          bclk;
  logic          lrck;
  logic          adcdat = 1'b0;
  logic [AW-1:0] maddr;
  logic [DW-1:0] mdata;
  logic          we;
  logic          ack = 1'b1;
  logic          ovr;
  logic          done;

  always #5 MCLK = ~MCLK;

  aud_in_multi #(.DATA_W(DW), .SLOT_W(SW), .BCLK_DIV(BD), .ADDR_W(AW)) dut (
    .MCLK(MCLK), .reset(reset), .enable(enable), .stereo(stereo), .loop(loop),
    .AUD_ADDR1(a1), .AUD_ADDR2(a2), .AUD_BCLK(bclk), .AUD_ADCLRCK(lrck),
    .AUD_ADCDAT(adcdat), .MEM_ADDR(maddr), .MEM_DATA(mdata), .MEM_WE(we),
    .MEM_ACK(ack), .overrun(ovr), .done(done)
  );

  // t = MCLK edges since the last edge that sampled reset high
  int t = 0;
  always @(posedge MCLK) t <= reset ? 0 : t + 1;

  typedef struct { int addr; int data; } wr_t;
  wr_t q[$];

  int checks = 0;
  int errors = 0;

  bit            fixed = 1'b1;
  logic [DW-1:0] fix_l = 6'h2A;
  logic [DW-1:0] fix_r = 6'h15;
  logic [DW-1:0] cur_word = '0;

  bit m_sync, m_run, m_stereo, m_loop, m_pend, m_ovr, m_done;
  int arm_t, push_t, m_addr, m_start, m_end, hs_cnt;
  bit prev_we, prev_ack;
  logic [AW-1:0] prev_addr;
  logic [DW-1:0] prev_data;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0d)", name, act, exp, t);
    end
  endtask

  // Per-cycle checks plus model update; runs at the falling edge
  task automatic monitor();
    wr_t w;
    bit  acc;
    int  b;
    chk("bclk", bclk, 64'((t % 4) >= 2));
    chk("lrck", lrck, 64'(((t / 32) % 2) == 0));
    if (reset) begin
      q.delete();
      m_run = 0; m_sync = 0; m_pend = 0; prev_we = 0; prev_ack = 0;
    end else begin
      if (prev_we && !prev_ack) begin
        chk("we_hold", we, 1);
        chk("addr_hold", maddr, prev_addr);
        chk("data_hold", mdata, prev_data);
      end else if (prev_we && prev_ack) begin
        chk("we_release", we, 0);
      end else if (we) begin
        chk("we_phase", t % 32, 22);
      end
      if (we && ack) begin
        hs_cnt++;
        if (q.size() == 0) begin
          chk("unexpected_write", 1, 0);
        end else begin
          w = q.pop_front();
          chk("wr_addr", maddr, w.addr);
          chk("wr_data", mdata, w.data);
        end
      end
      prev_we = we; prev_ack = ack; prev_addr = maddr; prev_data = mdata;

      if (!enable) begin
        m_run = 0; m_sync = 0;
      end
      if (m_sync && t >= arm_t + 2 && t % 64 == 31) begin
        m_sync = 0; m_run = 1;
      end
      acc = 0;
      if (m_run && t % 32 == 21 && (((t / 32) % 2) == 1 || m_stereo)) begin
        if (m_pend && !ack) m_ovr = 1;
        else                acc = 1;
      end
      if (m_pend && t > push_t && ack) m_pend = 0;
      if (acc) begin
        q.push_back('{m_addr, int'(cur_word)});
        m_pend = 1; push_t = t;
        m_addr = (m_addr + 1) % 256;
        if (m_addr == m_end) begin
          if (m_loop) m_addr = m_start;
          else begin m_run = 0; m_done = 1; end
        end
      end
    end
    if (t % 32 == 0)
      cur_word = fixed ? ((((t / 32) % 2) == 1) ? fix_l : fix_r) : DW'($urandom);
    b = (t / 4) % 8;
    adcdat = (b < DW) ? cur_word[DW-1-b] : 1'($urandom_range(0, 1));
  endtask

  task automatic cyc();
    @(negedge MCLK);
    monitor();
    @(posedge MCLK);
    #1;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic arm(input int s, input int e, input bit st, input bit lp);
    int n = 0;
    while (t % 64 != 40 && n < 200) begin cyc(); n++; end
    if (n >= 200) chk("arm_timeout", 0, 1);
    a1 = AW'(s); a2 = AW'(e); stereo = st; loop = lp; enable = 1;
    arm_t = t; m_start = s; m_end = e; m_addr = s; m_stereo = st; m_loop = lp;
    m_ovr = 0; m_done = (s >= e); m_sync = (s < e); m_run = 0; m_pend = 0;
    hs_cnt = 0;
  endtask

  task automatic wait_we(input string name);
    int n = 0;
    while (!we && n < 300) begin cyc(); n++; end
    if (n >= 300) chk(name, 0, 1);
  endtask

  initial begin
    repeat (3) @(posedge MCLK);
    #1;
    reset = 0;

    // free-running clocks after reset
    cycles(70);
    chk("s0_we", we, 0);
    chk("s0_done", done, 0);
    chk("s0_ovr", ovr, 0);
    chk("s0_addr", maddr, 0);

    // mono one-shot, window 8..11
    arm(8, 11, 0, 0);
    cycles(400);
    chk("s1_writes", hs_cnt, 3);
    chk("s1_done", done, 1);
    chk("s1_ovr", ovr, 0);
    chk("s1_end_addr", maddr, 11);
    chk("s1_queue_empty", q.size(), 0);
    enable = 0;
    cycles(3);
    chk("s1_done_clear", done, 0);

    // stereo loop, window 0..4
    fix_l = 6'h01; fix_r = 6'h3E;
    arm(0, 4, 1, 1);
    cycles(64 * 8);
    chk("s2_done", done, 0);
    chk("s2_ovr", ovr, 0);
    chk("s2_many_writes", 64'(hs_cnt >= 10), 1);
    enable = 0;
    cycles(40);

    // stereo with ack stalled for 40 cycles, random sample data
    fixed = 0;
    arm(0, 200, 1, 0);
    wait_we("s3_we_timeout");
    ack = 0;
    cycles(40);
    ack = 1;
    cycles(100);
    chk("s3_ovr", ovr, 1);
    chk("s3_ovr_model", ovr, m_ovr);
    chk("s3_done", done, 0);
    enable = 0;
    cycles(50);
    arm(0, 200, 1, 0);
    cycles(10);
    chk("s3_ovr_rearm", ovr, 0);

    // reset while a write is pending
    ack = 0;
    wait_we("s4_we_timeout");
    reset = 1;
    enable = 0;
    cyc();
    chk("s4_we", we, 0);
    chk("s4_addr", maddr, 0);
    chk("s4_lrck", lrck, 1);
    chk("s4_bclk", bclk, 0);
    reset = 0;
    ack = 1;
    cycles(20);

    // empty window
    arm(5, 5, 0, 0);
    cycles(2);
    chk("s5_done", done, 1);
    chk("s5_we", we, 0);
    cycles(10);
    chk("s5_writes", hs_cnt, 0);
    enable = 0;
    cycles(2);
    chk("s5_done_clear", done, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
